axi_wr_2_merger: RTL

- Two-master to one-slave AXI write merger; sits directly upstream of the 4-way write splitter and feeds its awid/aw*/w*/b port.
- Arbitrates AW round-robin and tags the source in the AW ID MSB.
- Steers W beats in AW grant order through an internal order FIFO.
- Routes B responses back by ID MSB; limits outstanding writes per source.

---
 rtl/axi_wr_2_merger_pkg.sv | 34 +++
 rtl/axi_wr_2_merger_syncfifo_sampled.sv | 48 ++++
 rtl/axi_wr_2_merger.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_2_merger_pkg.sv
// Shared definitions for the two-source AXI write merger: source-tag position,
// B response codes, arbiter lock state and the outstanding-write counter update.
package axi_wr_2_merger_pkg;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // The source index rides in the top bit of the merged write ID.
    function automatic int src_tag_pos(input int idwid);
        return idwid - 1;
    endfunction

    // A spurious B cannot retire a write, so an AW accepted alongside it still counts.
    function automatic logic [7:0] cnt_next(input logic [7:0] cnt,
                                            input logic       aw_hs,
                                            input logic       b_hs);
        logic [7:0] r;
        r = cnt;
        if (aw_hs && !b_hs) begin
            r = cnt + 8'd1;
        end else if (!aw_hs && b_hs && cnt != 8'd0) begin
            r = cnt - 8'd1;
        end else if (aw_hs && b_hs && cnt == 8'd0) begin
            r = 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_wr_2_merger_syncfifo_sampled.sv
// Synchronous FIFO whose flags and head are taken from registered state only,
// so a pushed entry becomes visible the cycle after the push.
module syncfifo_sampled
    import axi_wr_2_merger_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    // Pointers carry one wrap bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign dout  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wr_ptr[PW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_wr_2_merger.sv
// Two-master to one-slave AXI write merger: round-robin AW arbitration with lock,
// W steering in grant order, B routing by ID MSB and per-source outstanding limits.
module axi_wr_2_merger
    import axi_wr_2_merger_pkg::*;
#(
    parameter int AWID     = 32,
    parameter int EXTRAS   = 8,
    parameter int IDWID    = 4,
    parameter int DWID     = 64,
    parameter int WSTRB    = DWID / 8,
    parameter int ORDDEPTH = 8,
    parameter int MAXOUT   = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [IDWID-2:0]  s0_awid,
    input  logic [AWID-1:0]   s0_awaddr,
    input  logic [7:0]        s0_awlen,
    input  logic [2:0]        s0_awsize,
    input  logic [1:0]        s0_awburst,
    input  logic [EXTRAS-1:0] s0_awextras,
    input  logic              s0_awvalid,
    output logic              s0_awready,
    input  logic [DWID-1:0]   s0_wdata,
    input  logic [WSTRB-1:0]  s0_wstrb,
    input  logic              s0_wlast,
    input  logic              s0_wvalid,
    output logic              s0_wready,
    output logic [IDWID-2:0]  s0_bid,
    output logic [1:0]        s0_bresp,
    output logic              s0_bvalid,
    input  logic              s0_bready,

    input  logic [IDWID-2:0]  s1_awid,
    input  logic [AWID-1:0]   s1_awaddr,
    input  logic [7:0]        s1_awlen,
    input  logic [2:0]        s1_awsize,
    input  logic [1:0]        s1_awburst,
    input  logic [EXTRAS-1:0] s1_awextras,
    input  logic              s1_awvalid,
    output logic              s1_awready,
    input  logic [DWID-1:0]   s1_wdata,
    input  logic [WSTRB-1:0]  s1_wstrb,
    input  logic              s1_wlast,
    input  logic              s1_wvalid,
    output logic              s1_wready,
    output logic [IDWID-2:0]  s1_bid,
    output logic [1:0]        s1_bresp,
    output logic              s1_bvalid,
    input  logic              s1_bready,

    output logic [IDWID-1:0]  m_awid,
    output logic [AWID-1:0]   m_awaddr,
    output logic [7:0]        m_awlen,
    output logic [2:0]        m_awsize,
    output logic [1:0]        m_awburst,
    output logic [EXTRAS-1:0] m_awextras,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DWID-1:0]   m_wdata,
    output logic [WSTRB-1:0]  m_wstrb,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [IDWID-1:0]  m_bid,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,

    output logic              err_unexp_b
);

    localparam int         SRC_POS  = src_tag_pos(IDWID);
    localparam logic [7:0] MAXOUT_C = 8'(MAXOUT);

    // Handshakes: a transfer happens in the cycle where valid and ready are both
    // high; valid never waits on ready, and a raised valid holds its payload.

    arb_state_e state_q, state_d;
    logic       lock_src_q, lock_src_d;
    logic       rr_q;
    logic       gnt_src, gnt_valid;
    logic [7:0] cnt0_q, cnt1_q;
    logic       err_q;
    logic       elig0, elig1;
    logic       aw_hs, aw_hs0, aw_hs1;
    logic       b_msb, b_hs0, b_hs1;
    logic       ord_full, ord_empty, ord_head, ord_pop;

    assign elig0 = s0_awvalid && (cnt0_q < MAXOUT_C) && !ord_full;
    assign elig1 = s1_awvalid && (cnt1_q < MAXOUT_C) && !ord_full;

    // While locked the grant is pinned so the presented AW payload cannot change.
    always_comb begin
        state_d    = state_q;
        lock_src_d = lock_src_q;
        gnt_src    = rr_q;
        gnt_valid  = 1'b0;
        if (state_q == ARB_LOCKED) begin
            gnt_src   = lock_src_q;
            gnt_valid = lock_src_q ? elig1 : elig0;
        end else if (elig0 && elig1) begin
            gnt_src   = rr_q;
            gnt_valid = 1'b1;
        end else if (elig0) begin
            gnt_src   = 1'b0;
            gnt_valid = 1'b1;
        end else if (elig1) begin
            gnt_src   = 1'b1;
            gnt_valid = 1'b1;
        end
        if (gnt_valid && !m_awready) begin
            state_d    = ARB_LOCKED;
            lock_src_d = gnt_src;
        end else if (gnt_valid && m_awready) begin
            state_d = ARB_OPEN;
        end
    end

    assign m_awvalid  = gnt_valid;
    assign m_awid     = {gnt_src, (gnt_src ? s1_awid : s0_awid)};
    assign m_awaddr   = gnt_src ? s1_awaddr   : s0_awaddr;
    assign m_awlen    = gnt_src ? s1_awlen    : s0_awlen;
    assign m_awsize   = gnt_src ? s1_awsize   : s0_awsize;
    assign m_awburst  = gnt_src ? s1_awburst  : s0_awburst;
    assign m_awextras = gnt_src ? s1_awextras : s0_awextras;
    assign s0_awready = gnt_valid && !gnt_src && m_awready;
    assign s1_awready = gnt_valid &&  gnt_src && m_awready;

    assign aw_hs  = m_awvalid && m_awready;
    assign aw_hs0 = s0_awvalid && s0_awready;
    assign aw_hs1 = s1_awvalid && s1_awready;

    syncfifo_sampled #(
        .WIDTH (1),
        .DEPTH (ORDDEPTH)
    ) u_ord_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (aw_hs),
        .din   (gnt_src),
        .pop   (ord_pop),
        .dout  (ord_head),
        .full  (ord_full),
        .empty (ord_empty)
    );

    // W follows the head of the grant-order FIFO; an empty FIFO stalls both sources.
    assign m_wvalid  = !ord_empty && (ord_head ? s1_wvalid : s0_wvalid);
    assign m_wdata   = ord_head ? s1_wdata : s0_wdata;
    assign m_wstrb   = ord_head ? s1_wstrb : s0_wstrb;
    assign m_wlast   = ord_head ? s1_wlast : s0_wlast;
    assign s0_wready = !ord_empty && !ord_head && m_wready;
    assign s1_wready = !ord_empty &&  ord_head && m_wready;
    assign ord_pop   = m_wvalid && m_wready && m_wlast;

    assign b_msb     = m_bid[SRC_POS];
    assign s0_bvalid = m_bvalid && !b_msb;
    assign s1_bvalid = m_bvalid &&  b_msb;
    assign s0_bid    = m_bid[SRC_POS-1:0];
    assign s1_bid    = m_bid[SRC_POS-1:0];
    assign s0_bresp  = m_bresp;
    assign s1_bresp  = m_bresp;
    assign m_bready  = b_msb ? s1_bready : s0_bready;
    assign b_hs0     = s0_bvalid && s0_bready;
    assign b_hs1     = s1_bvalid && s1_bready;

    assign err_unexp_b = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_OPEN;
            lock_src_q <= 1'b0;
            rr_q       <= 1'b0;
            cnt0_q     <= 8'd0;
            cnt1_q     <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_src_q <= lock_src_d;
            if (aw_hs) begin
                rr_q <= !gnt_src;
            end
            cnt0_q <= cnt_next(cnt0_q, aw_hs0, b_hs0);
            cnt1_q <= cnt_next(cnt1_q, aw_hs1, b_hs1);
            if ((b_hs0 && cnt0_q == 8'd0) || (b_hs1 && cnt1_q == 8'd0)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
